// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the MEM-stage data memory (dmem_latency_unit).
//   - DATA_W / LANES : fixed 32-bit word made of four byte lanes
//   - CNT_W          : latency counter width (LATENCY is 1..15)
//   - size_e         : request size encoding (byte, half, word, reserved)
//   - state_e        : request FSM states
//   - ERR_CHECK_EN   : 1 when DMEM_ERR_CHECK_EN is defined. Then misaligned,
//                      reserved-size and out-of-range accesses raise rsp_err.
//                      When 0, rsp_err stays 0, H/W accesses are forced
//                      aligned, the reserved size acts as word, and the index
//                      wraps modulo DEPTH.
// Optional feature macro: DMEM_ERR_CHECK_EN
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_CHECK_EN = 1'b1;
`else
  localparam bit ERR_CHECK_EN = 1'b0;
`endif

endpackage

// File: rtl/dmem_latency_unit_if.sv
// -----------------------------------------------------------------------------
// dmem_latency_unit_if
// Request/response bundle between the MEM stage and the data memory.
//   req_valid/req_ready : request handshake (accept when both are high)
//   req_we              : 1 store, 0 load
//   req_size            : 00 byte, 01 half, 10 word, 11 reserved
//   req_signed          : loads sign-extend when 1, zero-extend when 0
//   req_addr            : byte address (ADDR_W bits)
//   req_wdata           : right-aligned store data
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata           : extended load data (0 for stores and errors)
//   rsp_err             : access error flag
// Modports: master = pipeline side, slave = memory side.
// -----------------------------------------------------------------------------
interface dmem_latency_unit_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane steering for the data memory.
//   size, offset  : access size and byte offset (addr[1:0])
//   sign_ext      : sign-extend loaded byte/half
//   wdata         : right-aligned store data
//   rword         : word read from the array at the access index
//   byte_en       : lanes a store writes
//   wdata_lanes   : store data replicated onto its lanes
//   rdata         : extracted and extended load data
//   misalign      : misaligned or reserved-size access (only when
//                   ERR_CHECK_EN, i.e. DMEM_ERR_CHECK_EN defined)
// Optional feature macro: DMEM_ERR_CHECK_EN (through dmem_pkg::ERR_CHECK_EN)
// -----------------------------------------------------------------------------
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e             size,
  input  logic [1:0]        offset,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [LANES-1:0]  byte_en,
  output logic [DATA_W-1:0] wdata_lanes,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign
);

  size_e      eff_size;
  logic [1:0] eff_off;
  logic [7:0] sel_b;
  logic [15:0] sel_h;

  // Without error checking the reserved size behaves as a word and
  // half/word accesses ignore the low address bits.
  assign eff_size = (!ERR_CHECK_EN && size == SIZE_RSV) ? SIZE_W : size;
  assign eff_off  = (!ERR_CHECK_EN && eff_size != SIZE_B) ? 2'b00 : offset;

  assign misalign = ERR_CHECK_EN &&
                    ((size == SIZE_RSV) ||
                     (size == SIZE_H && offset[0]) ||
                     (size == SIZE_W && offset != 2'b00));

  assign sel_b = rword[8*eff_off +: 8];
  assign sel_h = eff_off[1] ? rword[31:16] : rword[15:0];

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    byte_en     = '0;
    wdata_lanes = '0;
    rdata       = '0;
    case (eff_size)
      SIZE_B: begin
        byte_en     = 4'b0001 << eff_off;
        wdata_lanes = {4{wdata[7:0]}};
        rdata       = {{24{sign_ext & sel_b[7]}}, sel_b};
      end
      SIZE_H: begin
        byte_en     = eff_off[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata       = {{16{sign_ext & sel_h[15]}}, sel_h};
      end
      SIZE_W: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
        rdata       = rword;
      end
      default: ; // reserved size: flagged by misalign, touches nothing
    endcase
  end

endmodule

// File: rtl/dmem_latency_unit.sv
// -----------------------------------------------------------------------------
// dmem_latency_unit
// MEM-stage data memory: byte/half/word loads and stores with sign/zero
// extension, configurable depth and access latency, one outstanding request.
//   clk    : clock, all logic on the rising edge
//   reset  : synchronous, active-high
//   bus    : dmem_latency_unit_if.slave (request handshake + response)
// Parameters:
//   DEPTH   : number of 32-bit words (power of 2, >= 4)
//   ADDR_W  : byte-address width; index = addr[$clog2(DEPTH)+1:2]
//   LATENCY : cycles from accept edge to response edge (1..15)
// Timing: a request accepted at edge E0 is performed at edge E0+LATENCY (the
// edge leaving BUSY); rsp_valid is high for the cycle after that edge, in
// which req_ready is already high again.
// Optional feature macro: DMEM_ERR_CHECK_EN (error detection)
// -----------------------------------------------------------------------------
module dmem_latency_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_latency_unit_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              access;

  // Request fields captured at accept.
  logic              r_we;
  size_e             r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rword;
  logic [LANES-1:0]  byte_en;
  logic [DATA_W-1:0] wdata_lanes;
  logic [DATA_W-1:0] load_data;
  logic              misalign;
  logic              range_err;
  logic              err;

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  assign bus.req_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath capture needs no reset: the fields are only used after an
  // accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      r_we     <= bus.req_we;
      r_size   <= size_e'(bus.req_size);
      r_signed <= bus.req_signed;
      r_addr   <= bus.req_addr;
      r_wdata  <= bus.req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode and lane steering
  // ---------------------------------------------------------------------------
  assign idx   = r_addr[IDX_W+1:2];
  assign rword = mem[idx];

  generate
    if (ADDR_W > IDX_W + 2) begin : g_range
      assign range_err = ERR_CHECK_EN && (|r_addr[ADDR_W-1:IDX_W+2]);
    end else begin : g_no_range
      assign range_err = 1'b0;
    end
  endgenerate

  assign err = misalign | range_err;

  dmem_lane_align u_lane_align (
    .size        (r_size),
    .offset      (r_addr[1:0]),
    .sign_ext    (r_signed),
    .wdata       (r_wdata),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata       (load_data),
    .misalign    (misalign)
  );

  // ---------------------------------------------------------------------------
  // Array: a store commits on the access edge unless it is in error or a
  // reset arrives on that same edge (an abandoned request leaves no trace).
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; contents survive reset and the block maps
  // onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && access && r_we && !err) begin
      for (int l = 0; l < LANES; l++) begin
        if (byte_en[l]) mem[idx][8*l +: 8] <= wdata_lanes[8*l +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= access;
      if (access) begin
        rsp_err_q   <= err;
        rsp_rdata_q <= (err || r_we) ? '0 : load_data;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_latency_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_latency_unit
// Self-checking bench for dmem_latency_unit. A LATENCY=1 instance takes
// directed and random traffic compared against a byte-addressed reference
// memory; a LATENCY=3 instance is driven with req_valid held high to check
// ready/response cadence. Honours DMEM_ERR_CHECK_EN the same way as the RTL.
// -----------------------------------------------------------------------------
module tb_dmem_latency_unit;

  localparam int          DEPTH     = 256;
  localparam int unsigned MEM_BYTES = DEPTH * 4;
  localparam int          LAT1      = 1;

  logic clk = 1'b0;
  logic reset;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [7:0] mm [MEM_BYTES];

  always #5 clk = ~clk;

  dmem_latency_unit_if #(.ADDR_W(32)) b1 ();
  dmem_latency_unit_if #(.ADDR_W(32)) b3 ();

  dmem_latency_unit #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  dmem_latency_unit #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: little-endian byte memory, access rules applied arithmetically.
  function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er);
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] v;
    int unsigned nb;
    sz = size;
    a  = addr;
    rd = '0;
`ifdef DMEM_ERR_CHECK_EN
    er = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
         (size == 2'd2 && addr[1:0] != 2'b00) || (addr >= MEM_BYTES);
`else
    er = 1'b0;
    if (sz == 2'd3) sz = 2'd2;
    if (sz != 2'd0) a[1:0] = 2'b00;
    a = a % MEM_BYTES;
`endif
    if (er) return;
    nb = 1 << sz;
    if (we) begin
      for (int i = 0; i < int'(nb); i++) mm[a + i] = wdata[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < int'(nb); i++) v = v | (32'(mm[a + i]) << (8*i));
      if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rd = v;
    end
  endfunction

  // One request on the LATENCY=1 instance, checked against the model.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          waited;
    model(we, size, sgn, addr, wdata, exp_rd, exp_er);
    @(negedge clk);
    b1.req_valid  = 1'b1;
    b1.req_we     = we;
    b1.req_size   = size;
    b1.req_signed = sgn;
    b1.req_addr   = addr;
    b1.req_wdata  = wdata;
    waited = 0;
    while (!b1.req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, ".ready"}, 32'(b1.req_ready), 32'd1);
    @(posedge clk);
    #1 b1.req_valid = 1'b0;
    for (int i = 1; i <= LAT1; i++) begin
      @(negedge clk);
      check({tag, ".early_rsp"}, 32'(b1.rsp_valid), 32'd0);
    end
    @(negedge clk);
    check({tag, ".rsp_valid"}, 32'(b1.rsp_valid), 32'd1);
    check({tag, ".rsp_err"}, 32'(b1.rsp_err), 32'(exp_er));
    check({tag, ".rdata"}, b1.rsp_rdata, exp_rd);
  endtask

  // Watchdog: the bench must always terminate.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        we3   [6];
  logic [31:0] addr3 [6];
  logic [31:0] wd3   [6];
  logic [31:0] exp3  [6];

  initial begin
    logic [31:0] last3 [int];
    int          nxt;
    logic [1:0]  rs;
    logic [31:0] ra;

    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_size = 2'd0;
    b1.req_signed = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
    b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_size = 2'd0;
    b3.req_signed = 1'b0; b3.req_addr = '0; b3.req_wdata = '0;

    // Reset with a request pending: reset wins, nothing is accepted.
    reset = 1'b1;
    b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_size = 2'd2;
    b1.req_addr = 32'h10; b1.req_wdata = 32'h5555_5555;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.rsp_valid", 32'(b1.rsp_valid), 32'd0);
    check("reset.rsp_rdata", b1.rsp_rdata, 32'd0);
    check("reset.rsp_err", 32'(b1.rsp_err), 32'd0);
    check("reset.ready", 32'(b1.req_ready), 32'd1);
    check("reset.ready3", 32'(b3.req_ready), 32'd1);
    reset = 1'b0;
    b1.req_valid = 1'b0;
    @(negedge clk);
    check("post_reset.rsp_valid", 32'(b1.rsp_valid), 32'd0);
    check("post_reset.ready", 32'(b1.req_ready), 32'd1);

    // Give every word a known value.
    for (int w = 0; w < DEPTH; w++) issue(1'b1, 2'd2, 1'b0, 32'(4 * w), $urandom, "fill");

    // Word store/load, single-cycle response pulse.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, "sw_10");
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw_10");
    @(negedge clk);
    check("lw_10.pulse_end", 32'(b1.rsp_valid), 32'd0);

    // Byte store into a cleared word, then signed/unsigned byte and word loads.
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, "sw_20");
    issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h80, "sb_21");
    issue(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, "lb_21");
    issue(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, "lbu_21");
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "lw_20");

    // Half store/load, misaligned half store, word unchanged check.
    issue(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000_BEEF, "sh_32");
    issue(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, "lh_32");
    issue(1'b1, 2'd1, 1'b0, 32'h33, 32'h0000_1111, "sh_33");
    issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "lw_30");

    // Reserved size and out-of-range address.
    issue(1'b0, 2'd3, 1'b0, 32'h44, 32'h0, "rsv_44");
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, "lw_400");
    issue(1'b1, 2'd2, 1'b0, 32'h404, 32'hCAFE_F00D, "sw_404");
    issue(1'b0, 2'd2, 1'b0, 32'h004, 32'h0, "lw_004");

    // Reset while BUSY: store abandoned, no response.
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_size = 2'd2;
    b1.req_signed = 1'b0; b1.req_addr = 32'h40; b1.req_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 b1.req_valid = 1'b0;
    @(negedge clk);
    check("rst_busy.ready_low", 32'(b1.req_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy.no_rsp", 32'(b1.rsp_valid), 32'd0);
    check("rst_busy.idle", 32'(b1.req_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy.no_rsp2", 32'(b1.rsp_valid), 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "lw_40_after_rst");

    // Randomised traffic.
    for (int k = 0; k < 300; k++) begin
      rs = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES - 1));
      issue(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom, "rand");
    end

    // LATENCY=3 with req_valid held high: accept every 4th cycle, none lost.
    for (int k = 0; k < 6; k++) begin
      we3[k]   = (k % 2 == 0);
      addr3[k] = (k % 4 < 2) ? 32'h100 : 32'h104;
      wd3[k]   = $urandom;
      if (we3[k]) begin
        last3[int'(addr3[k])] = wd3[k];
        exp3[k] = 32'h0;
      end else begin
        exp3[k] = last3[int'(addr3[k])];
      end
    end
    nxt = 0;
    for (int n = 0; n <= 24; n++) begin
      @(negedge clk);
      check($sformatf("lat3.ready[%0d]", n), 32'(b3.req_ready), 32'((n % 4) == 0));
      check($sformatf("lat3.rsp_valid[%0d]", n), 32'(b3.rsp_valid), 32'((n % 4) == 0 && n > 0));
      if ((n % 4) == 0 && n > 0) begin
        check($sformatf("lat3.rdata[%0d]", n / 4 - 1), b3.rsp_rdata, exp3[n / 4 - 1]);
        check($sformatf("lat3.err[%0d]", n / 4 - 1), 32'(b3.rsp_err), 32'd0);
      end
      if (b3.req_ready) begin
        if (nxt < 6) begin
          b3.req_valid  = 1'b1;
          b3.req_we     = we3[nxt];
          b3.req_size   = 2'd2;
          b3.req_signed = 1'b0;
          b3.req_addr   = addr3[nxt];
          b3.req_wdata  = wd3[nxt];
          nxt++;
        end else begin
          b3.req_valid = 1'b0;
        end
      end
    end
    b3.req_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
